// File: rtl/op_lut_eth_parser_if.sv
// Snooped AXI-Stream ingress bus shared by the input packet FIFO and the
// Ethernet header parser. The parser only observes the bus, so its modport
// is input-only.
interface op_lut_eth_parser_if #(
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_TUSER_WIDTH = 128
);
    logic [C_S_AXIS_DATA_WIDTH-1:0]  tdata;
    logic [C_S_AXIS_TUSER_WIDTH-1:0] tuser;
    logic                            tvalid;
    logic                            tready;
    logic                            tlast;

    // Stream source side (driver of the bus, including the sink's ready).
    modport master (
        output tdata,
        output tuser,
        output tvalid,
        output tready,
        output tlast
    );

    // Passive observer side: sees every beat, never stalls the stream.
    modport slave (
        input tdata,
        input tuser,
        input tvalid,
        input tready,
        input tlast
    );
endinterface

// File: rtl/op_lut_eth_parser.sv
// Ethernet header parser for the router output-port lookup.
// Watches the ingress stream, classifies beat 0 of every packet (ARP/IPv4,
// broadcast, destined to one of our MACs) and queues one record per packet
// in a small first-word-fall-through FIFO. The downstream process FSM reads
// the head record combinationally and pops it with a one-cycle strobe.
module op_lut_eth_parser #(
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int NUM_QUEUES           = 8,
    parameter int NUM_QUEUES_WIDTH     = $clog2(NUM_QUEUES),
    parameter int INFO_FIFO_DEPTH      = 4
) (
    input  logic                        clk,
    input  logic                        reset,

    op_lut_eth_parser_if.slave          axis,

    input  logic [47:0]                 mac_0,
    input  logic [47:0]                 mac_1,
    input  logic [47:0]                 mac_2,
    input  logic [47:0]                 mac_3,

    input  logic                        rd_eth_parser,

    output logic                        is_arp_pkt,
    output logic                        is_ip_pkt,
    output logic                        is_for_us,
    output logic                        is_broadcast,
    output logic [NUM_QUEUES_WIDTH-1:0] mac_dst_port_num,
    output logic                        eth_parser_info_vld,
    output logic                        info_fifo_overflow
);

    localparam int PTR_W = $clog2(INFO_FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [15:0] ETHTYPE_IP  = 16'h0800;
    localparam logic [15:0] ETHTYPE_ARP = 16'h0806;
    localparam logic [47:0] MAC_BCAST   = 48'hFFFF_FFFF_FFFF;

    typedef enum logic [0:0] {
        WAIT_HDR = 1'b0,
        IN_PKT   = 1'b1
    } state_t;

    typedef struct packed {
        logic                        is_arp;
        logic                        is_ip;
        logic                        is_for_us;
        logic                        is_broadcast;
        logic [NUM_QUEUES_WIDTH-1:0] port;
    } info_rec_t;

    // ------------------------------------------------------------------
    // Header field extraction
    // ------------------------------------------------------------------
    logic        beat;
    logic [47:0] dst_mac;
    logic [15:0] ethertype;
    logic [47:0] mac_tbl [4];

    assign beat      = axis.tvalid & axis.tready;
    assign dst_mac   = axis.tdata[47:0];
    assign ethertype = axis.tdata[111:96];

    assign mac_tbl[0] = mac_0;
    assign mac_tbl[1] = mac_1;
    assign mac_tbl[2] = mac_2;
    assign mac_tbl[3] = mac_3;

    // Source MAC, the rest of the beat and tuser are deliberately not parsed;
    // the consumer resolves the source port against its own input port.
    logic unused_axis_bits;
    assign unused_axis_bits = ^{axis.tdata[C_S_AXIS_DATA_WIDTH-1:112],
                                axis.tdata[95:48], axis.tuser};

    // Classify the current beat as if it were a header; only used on push.
    info_rec_t rec_new;
    logic      mac_match;

    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        rec_new   = '0;
        mac_match = 1'b0;
        // Walk from lowest to highest priority so mac_0 wins on duplicates.
        for (int k = 3; k >= 0; k--) begin
            if (dst_mac == mac_tbl[k]) begin
                mac_match    = 1'b1;
                rec_new.port = NUM_QUEUES_WIDTH'(2 * k);
            end
        end
        rec_new.is_ip        = (ethertype == ETHTYPE_IP);
        rec_new.is_arp       = (ethertype == ETHTYPE_ARP);
        rec_new.is_broadcast = (dst_mac == MAC_BCAST);
        rec_new.is_for_us    = mac_match | rec_new.is_broadcast;
    end

    // ------------------------------------------------------------------
    // Packet framing FSM: only the first beat of each packet is a header
    // ------------------------------------------------------------------
    state_t state_q;
    state_t state_d;
    logic   hdr_push;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples its pre-edge inputs regardless of block order.
        if (reset) state_q <= WAIT_HDR;
        else       state_q <= state_d;
    end

    // Next state and header-push strobe.
    always_comb begin
        state_d  = state_q;
        hdr_push = 1'b0;
        unique case (state_q)
            WAIT_HDR: begin
                if (beat) begin
                    hdr_push = 1'b1;
                    if (!axis.tlast) state_d = IN_PKT;
                end
            end
            IN_PKT: begin
                if (beat && axis.tlast) state_d = WAIT_HDR;
            end
            default: state_d = WAIT_HDR;
        endcase
    end

    // ------------------------------------------------------------------
    // Info FIFO (first-word fall-through)
    // ------------------------------------------------------------------
    info_rec_t        mem [INFO_FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             empty;
    logic             full;
    logic             pop;
    logic             push_ok;
    logic             overflow_d;
    logic             overflow_q;

    assign empty      = (count == '0);
    assign full       = (count == CNT_W'(INFO_FIFO_DEPTH));
    assign pop        = rd_eth_parser & ~empty;
    // A pop in the same cycle frees the slot the new header needs.
    assign push_ok    = hdr_push & (~full | pop);
    assign overflow_d = hdr_push & full & ~pop;

    // Record storage.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset; entries are only observable
        // once written, because the outputs are gated by the non-empty flag.
        if (push_ok) mem[wr_ptr] <= rec_new;
    end

    // Pointers, occupancy and overflow pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            unique case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            overflow_q <= overflow_d;
        end
    end

    // ------------------------------------------------------------------
    // Head record outputs, forced to zero while the FIFO is empty
    // ------------------------------------------------------------------
    info_rec_t head;

    assign head                = empty ? '0 : mem[rd_ptr];
    assign eth_parser_info_vld = ~empty;
    assign is_arp_pkt          = head.is_arp;
    assign is_ip_pkt           = head.is_ip;
    assign is_for_us           = head.is_for_us;
    assign is_broadcast        = head.is_broadcast;
    assign mac_dst_port_num    = head.port;
    assign info_fifo_overflow  = overflow_q;

endmodule
